// File: rtl/croc_pkg.sv
// Shared constants and helpers for the interrupt front-end: register offsets,
// core IRQ id mapping and the 17-bit interrupt field layout.
package croc_pkg;

  localparam logic [3:0] IrqCtrlPendingOffs = 4'h0;
  localparam logic [3:0] IrqCtrlEnableOffs  = 4'h4;
  localparam logic [3:0] IrqCtrlTriggerOffs = 4'h8;
  localparam logic [3:0] IrqCtrlActiveOffs  = 4'hC;

  localparam int unsigned CoreIrqFastBase = 16;
  localparam int unsigned CoreIrqTimerId  = 7;
  localparam int unsigned IrqCtrlTimerBit = 16;
  localparam int unsigned IrqCtrlWidth    = 17;

  typedef logic [IrqCtrlWidth-1:0] irq_vec_t;

  typedef enum logic [1:0] {
    RegPending = IrqCtrlPendingOffs[3:2],
    RegEnable  = IrqCtrlEnableOffs[3:2],
    RegTrigger = IrqCtrlTriggerOffs[3:2],
    RegActive  = IrqCtrlActiveOffs[3:2]
  } irq_reg_e;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_line_sync.sv
// Per-bit flop chain for asynchronous interrupt lines; Stages cycles of latency,
// Stages == 0 is a straight wire. No backpressure.
module irq_line_sync #(
  parameter int unsigned Width  = 17,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Stages == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_sync
    logic [Width-1:0] sync_d [Stages];
    logic [Width-1:0] sync_q [Stages];

    always_comb begin
      sync_d[0] = d_i;
      for (int k = 1; k < Stages; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < Stages; k++) begin
          sync_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < Stages; k++) begin
          sync_q[k] <= sync_d[k];
        end
      end
    end

    assign q_o = sync_q[Stages-1];
  end

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt front-end for the core: sync, pending/enable/trigger state, ack clearing.
// Input edge reaches irq_o after SyncStages+1 cycles; register port never stalls, 1-cycle response.
module core_irq_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned NumExtIrq  = 16,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumExtIrq-1:0] irqs_i,
  input  logic                 timer0_irq_i,
  output logic [31:0]          irq_o,
  input  logic                 irq_ack_i,
  input  logic [4:0]           irq_id_i,
  input  logic                 reg_req_i,
  output logic                 reg_gnt_o,
  input  logic [3:0]           reg_addr_i,
  input  logic                 reg_we_i,
  input  logic [3:0]           reg_be_i,
  input  logic [31:0]          reg_wdata_i,
  output logic                 reg_rvalid_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_err_o
);

  localparam irq_vec_t ValidMask =
      irq_vec_t'((17'h1 << NumExtIrq) - 17'h1) | irq_vec_t'(17'h1 << IrqCtrlTimerBit);
  // Timer is hard-wired to level mode, so its trigger bit is never stored.
  localparam irq_vec_t TrigMask = ValidMask & ~irq_vec_t'(17'h1 << IrqCtrlTimerBit);

  irq_vec_t raw_irq;
  irq_vec_t s_irq;

  irq_vec_t prev_d,    prev_q;
  irq_vec_t pending_d, pending_q;
  irq_vec_t enable_d,  enable_q;
  irq_vec_t trigger_d, trigger_q;
  logic        rvalid_d, rvalid_q;
  logic [31:0] rdata_d,  rdata_q;
  logic        err_d,    err_q;

  logic        addr_ok;
  logic        wr_en;
  logic        rd_en;
  irq_reg_e    word;
  logic [31:0] wmask;
  irq_vec_t    wdata;
  irq_vec_t    bmask;
  irq_vec_t    w1c;
  irq_vec_t    mode_chg;
  irq_vec_t    ack_hit;
  irq_vec_t    edge_set;
  logic        unused_hi;

  always_comb begin
    raw_irq                  = '0;
    raw_irq[NumExtIrq-1:0]   = irqs_i;
    raw_irq[IrqCtrlTimerBit] = timer0_irq_i;
  end

  irq_line_sync #(
    .Width  (IrqCtrlWidth),
    .Stages (SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (raw_irq),
    .q_o    (s_irq)
  );

  assign reg_gnt_o = reg_req_i;
  assign addr_ok   = (reg_addr_i[1:0] == 2'b00);
  assign wr_en     = reg_req_i & addr_ok & reg_we_i;
  assign rd_en     = reg_req_i & addr_ok & ~reg_we_i;
  assign word      = irq_reg_e'(reg_addr_i[3:2]);
  assign wmask     = be_to_mask(reg_be_i);
  assign bmask     = wmask[IrqCtrlWidth-1:0];
  assign wdata     = reg_wdata_i[IrqCtrlWidth-1:0];
  assign unused_hi = ^{reg_wdata_i[31:IrqCtrlWidth], wmask[31:IrqCtrlWidth]};

  // Software register writes
  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    w1c       = '0;
    if (wr_en) begin
      case (word)
        RegPending: w1c       = wdata & bmask & ValidMask;
        RegEnable:  enable_d  = ((enable_q & ~bmask) | (wdata & bmask)) & ValidMask;
        RegTrigger: trigger_d = ((trigger_q & ~bmask) | (wdata & bmask)) & TrigMask;
        default:    ;
      endcase
    end
  end

  // Pending update: level lines follow the synchroniser; edge lines latch rising edges
  always_comb begin
    prev_d   = s_irq;
    mode_chg = trigger_q ^ trigger_d;
    edge_set = s_irq & ~prev_q;
    ack_hit  = '0;
    for (int i = 0; i < NumExtIrq; i++) begin
      if (irq_ack_i && (irq_id_i == 5'(CoreIrqFastBase + i))) begin
        ack_hit[i] = 1'b1;
      end
    end
    pending_d = '0;
    for (int i = 0; i < IrqCtrlWidth; i++) begin
      if (mode_chg[i]) begin
        pending_d[i] = 1'b0;
      end else if (!trigger_q[i]) begin
        pending_d[i] = s_irq[i];
      end else if (edge_set[i]) begin
        pending_d[i] = 1'b1;
      end else if (ack_hit[i] || w1c[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
    pending_d = pending_d & ValidMask;
  end

  // Read data reflects state before this cycle's updates
  always_comb begin
    rvalid_d = reg_req_i;
    err_d    = reg_req_i & ~addr_ok;
    rdata_d  = '0;
    if (rd_en) begin
      case (word)
        RegPending: rdata_d = {15'b0, pending_q};
        RegEnable:  rdata_d = {15'b0, enable_q};
        RegTrigger: rdata_d = {15'b0, trigger_q};
        RegActive:  rdata_d = {15'b0, pending_q & enable_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      trigger_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_err_o    = err_q;

  always_comb begin
    irq_o = '0;
    for (int i = 0; i < NumExtIrq; i++) begin
      irq_o[CoreIrqFastBase + i] = pending_q[i] & enable_q[i];
    end
    irq_o[CoreIrqTimerId] = pending_q[IrqCtrlTimerBit] & enable_q[IrqCtrlTimerBit];
  end

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Directed bench for core_irq_ctrl with default parameters (16 lines, 2 sync stages).
module tb_core_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] irqs;
  logic        timer;
  logic [31:0] irq_o;
  logic        ack;
  logic [4:0]  ack_id;
  logic        req;
  logic        gnt;
  logic [3:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  core_irq_ctrl #(.NumExtIrq(16), .SyncStages(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .irqs_i       (irqs),
    .timer0_irq_i (timer),
    .irq_o        (irq_o),
    .irq_ack_i    (ack),
    .irq_id_i     (ack_id),
    .reg_req_i    (req),
    .reg_gnt_o    (gnt),
    .reg_addr_i   (addr),
    .reg_we_i     (we),
    .reg_be_i     (be),
    .reg_wdata_i  (wdata),
    .reg_rvalid_o (rvalid),
    .reg_rdata_o  (rdata),
    .reg_err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request at a negedge; return the response sampled at the following negedge.
  task automatic reg_op(input logic w, input logic [3:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output logic v);
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    rd  = rdata;
    e   = err;
    v   = rvalid;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic e, v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (irq_o !== 32'h0) begin bad++; $display("FAIL reset_irq got=%h want=%h", irq_o, 32'h0); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL idle_gnt got=%b want=0", gnt); end
    for (int k = 0; k < 4; k++) begin
      reg_op(1'b0, 4'(k * 4), 4'hF, 32'h0, rd, e, v);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_rd%0d got=%h want=%h", k, rd, 32'h0); end
      total++; if (e !== 1'b0)   begin bad++; $display("FAIL reset_err%0d got=%b want=0", k, e); end
      total++; if (v !== 1'b1)   begin bad++; $display("FAIL reset_rvalid%0d got=%b want=1", k, v); end
    end
    @(negedge clk);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_drop got=%b want=0", rvalid); end
  endtask

  task automatic test_timer();
    logic [31:0] rd;
    logic e, v;
    reg_op(1'b1, 4'h4, 4'hF, 32'h0001_0000, rd, e, v);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h want=%h", rd, 32'h0); end
    timer = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++; if (irq_o !== 32'h0)  begin bad++; $display("FAIL timer_early got=%h want=%h", irq_o, 32'h0); end
    @(negedge clk);
    total++; if (irq_o !== 32'h80) begin bad++; $display("FAIL timer_set got=%h want=%h", irq_o, 32'h80); end
    timer = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++; if (irq_o !== 32'h80) begin bad++; $display("FAIL timer_hold got=%h want=%h", irq_o, 32'h80); end
    @(negedge clk);
    total++; if (irq_o !== 32'h0)  begin bad++; $display("FAIL timer_clr got=%h want=%h", irq_o, 32'h0); end
  endtask

  task automatic test_edge_ack();
    logic [31:0] rd;
    logic e, v;
    reg_op(1'b1, 4'h8, 4'hF, 32'h0000_0008, rd, e, v);
    reg_op(1'b1, 4'h4, 4'hF, 32'h0001_0008, rd, e, v);
    irqs[3] = 1'b1;
    @(negedge clk);
    irqs[3] = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (irq_o !== 32'h0008_0000) begin bad++; $display("FAIL edge_latched got=%h want=%h", irq_o, 32'h0008_0000); end
    ack = 1'b1; ack_id = 5'd20;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    total++; if (irq_o !== 32'h0008_0000) begin bad++; $display("FAIL ack_wrong_id got=%h want=%h", irq_o, 32'h0008_0000); end
    ack = 1'b1; ack_id = 5'd19;
    @(negedge clk);
    ack = 1'b0;
    total++; if (irq_o !== 32'h0) begin bad++; $display("FAIL ack_clear got=%h want=%h", irq_o, 32'h0); end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    logic e, v;
    reg_op(1'b1, 4'h8, 4'hF, 32'h0000_0009, rd, e, v);
    irqs[0] = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reg_op(1'b1, 4'h0, 4'hF, 32'h0000_0001, rd, e, v);
    reg_op(1'b0, 4'h0, 4'hF, 32'h0, rd, e, v);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL set_wins got=%h want=%h", rd, 32'h1); end
    reg_op(1'b1, 4'h0, 4'hF, 32'h0000_0001, rd, e, v);
    reg_op(1'b0, 4'h0, 4'hF, 32'h0, rd, e, v);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h want=%h", rd, 32'h0); end
    irqs[0] = 1'b0;
  endtask

  task automatic test_level();
    logic [31:0] rd;
    logic e, v;
    reg_op(1'b1, 4'h4, 4'hF, 32'h0001_0028, rd, e, v);
    irqs[5] = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (irq_o !== 32'h0020_0000) begin bad++; $display("FAIL level_set got=%h want=%h", irq_o, 32'h0020_0000); end
    reg_op(1'b0, 4'hC, 4'hF, 32'h0, rd, e, v);
    total++; if (rd !== 32'h20) begin bad++; $display("FAIL active_rd got=%h want=%h", rd, 32'h20); end
    ack = 1'b1; ack_id = 5'd21;
    @(negedge clk);
    ack = 1'b0;
    reg_op(1'b1, 4'h0, 4'hF, 32'h0000_0020, rd, e, v);
    total++; if (irq_o !== 32'h0020_0000) begin bad++; $display("FAIL level_sticky got=%h want=%h", irq_o, 32'h0020_0000); end
    irqs[5] = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (irq_o !== 32'h0020_0000) begin bad++; $display("FAIL level_hold got=%h want=%h", irq_o, 32'h0020_0000); end
    @(negedge clk);
    total++; if (irq_o !== 32'h0) begin bad++; $display("FAIL level_clr got=%h want=%h", irq_o, 32'h0); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic e, v;
    reg_op(1'b0, 4'h2, 4'hF, 32'h0, rd, e, v);
    total++; if (e !== 1'b1)   begin bad++; $display("FAIL err_rd got=%b want=1", e); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_rdata got=%h want=%h", rd, 32'h0); end
    total++; if (v !== 1'b1)   begin bad++; $display("FAIL err_rvalid got=%b want=1", v); end
    reg_op(1'b1, 4'h5, 4'hF, 32'h0, rd, e, v);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_wr got=%b want=1", e); end
    reg_op(1'b0, 4'h4, 4'hF, 32'h0, rd, e, v);
    total++; if (rd !== 32'h0001_0028) begin bad++; $display("FAIL err_nochange got=%h want=%h", rd, 32'h0001_0028); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ok_err got=%b want=0", e); end
    reg_op(1'b1, 4'h8, 4'b0001, 32'hFFFF_FFFF, rd, e, v);
    reg_op(1'b0, 4'h8, 4'hF, 32'h0, rd, e, v);
    total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL trig_be got=%h want=%h", rd, 32'h0000_00FF); end
    reg_op(1'b1, 4'hC, 4'hF, 32'hFFFF_FFFF, rd, e, v);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL active_wr_err got=%b want=0", e); end
    reg_op(1'b0, 4'h4, 4'hF, 32'h0, rd, e, v);
    total++; if (rd !== 32'h0001_0028) begin bad++; $display("FAIL active_wr_ignored got=%h want=%h", rd, 32'h0001_0028); end
  endtask

  task automatic test_back_to_back();
    req = 1'b1; we = 1'b0; addr = 4'h4; be = 4'hF;
    @(posedge clk); @(negedge clk);
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL b2b_v0 got=%b want=1", rvalid); end
    total++; if (rdata !== 32'h0001_0028) begin bad++; $display("FAIL b2b_d0 got=%h want=%h", rdata, 32'h0001_0028); end
    addr = 4'h8;
    @(posedge clk); @(negedge clk);
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL b2b_v1 got=%b want=1", rvalid); end
    total++; if (rdata !== 32'h0000_00FF) begin bad++; $display("FAIL b2b_d1 got=%h want=%h", rdata, 32'h0000_00FF); end
    req = 1'b0;
    @(negedge clk);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", rvalid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic e, v;
    req = 1'b1; we = 1'b0; addr = 4'h4; be = 4'hF;
    @(posedge clk);
    #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b want=1", rvalid); end
    rst_n = 1'b0;
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_drop got=%b want=0", rvalid); end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reg_op(1'b0, 4'h4, 4'hF, 32'h0, rd, e, v);
    total++; if (v !== 1'b1)   begin bad++; $display("FAIL mid_after_v got=%b want=1", v); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_after_d got=%h want=%h", rd, 32'h0); end
  endtask

  initial begin
    rst_n  = 1'b0;
    irqs   = '0;
    timer  = 1'b0;
    ack    = 1'b0;
    ack_id = '0;
    req    = 1'b0;
    addr   = '0;
    we     = 1'b0;
    be     = '0;
    wdata  = '0;
    @(negedge clk);
    test_reset();
    test_timer();
    test_edge_ack();
    test_set_wins();
    test_level();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
